mem_access_unit: RTL and testbench

- MEM-stage consumer of the decoder's memory controls (mem_read_enM, mem_write_enM).
- Turns each lw/sw reaching MEM into one transaction on the data-side SRAM-like bus: req/addr_ok, then data_ok.
- Stalls the pipeline until the transaction completes.
- Holds load data stable until the MEM stage advances.

---
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus master: turns one lw/sw per MEM instruction into a single
// req/addr_ok/data_ok transaction, stalling MEM until it finishes.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   mem_read_enM       load in MEM
//   mem_write_enM      store in MEM (read wins if both set)
//   flushM             cancel MEM instruction (only honoured in IDLE)
//   stall_other        pipeline held by another stage
//   addrM, write_dataM effective address / store data
//   read_dataM         load result, valid and held in DONE
//   stallM             MEM not finished (combinational)
//   addr_errM          misaligned word access (combinational)
//   data_req/wr/addr/wdata/wstrb   bus request side
//   data_addr_ok/data_data_ok/data_rdata  bus response side
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_read_enM,
  input  logic              mem_write_enM,
  input  logic              flushM,
  input  logic              stall_other,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] write_dataM,
  output logic [DATA_W-1:0] read_dataM,
  output logic              stallM,
  output logic              addr_errM,
  output logic              data_req,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;

  logic mem_en;
  logic access;
  logic latch_en;
  logic cap_en;

  assign mem_en    = mem_read_enM | mem_write_enM;
  assign addr_errM = mem_en & (addrM[1:0] != 2'b00);
  assign access    = mem_en & ~addr_errM & ~flushM;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (latch_en) begin
        addr_q  <= addrM;
        wdata_q <= write_dataM;
        // a load with both enables set is treated as a load
        wr_q    <= mem_write_enM & ~mem_read_enM;
      end
      if (cap_en) begin
        rdata_q <= data_rdata;
      end
    end
  end

  always_comb begin
    state_n  = state;
    latch_en = 1'b0;
    cap_en   = 1'b0;
    data_req = 1'b0;
    stallM   = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          latch_en = 1'b1;
          stallM   = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        // request stays up until accepted; data_ok before
        // acceptance is meaningless and ignored
        data_req = 1'b1;
        stallM   = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            cap_en  = ~wr_q;
            state_n = DONE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        stallM = 1'b1;
        if (data_data_ok) begin
          cap_en  = ~wr_q;
          state_n = DONE;
        end
      end
      DONE: begin
        // enables still asserted here belong to the finished
        // instruction, so no new request until MEM advances
        if (!stall_other) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign read_dataM = rdata_q;
  assign data_wr    = wr_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = {4{wr_q}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, bus wait states,
// stall_other hold, misalignment, flush and mid-transaction reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_read_enM;
  logic        mem_write_enM;
  logic        flushM;
  logic        stall_other;
  logic [31:0] addrM;
  logic [31:0] write_dataM;
  logic [31:0] read_dataM;
  logic        stallM;
  logic        addr_errM;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_read_enM (mem_read_enM),
    .mem_write_enM(mem_write_enM),
    .flushM       (flushM),
    .stall_other  (stall_other),
    .addrM        (addrM),
    .write_dataM  (write_dataM),
    .read_dataM   (read_dataM),
    .stallM       (stallM),
    .addr_errM    (addr_errM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn        = 1'b0;
    mem_read_enM  = 1'b0;
    mem_write_enM = 1'b0;
    flushM        = 1'b0;
    stall_other   = 1'b0;
    addrM         = '0;
    write_dataM   = '0;
    data_addr_ok  = 1'b0;
    data_data_ok  = 1'b0;
    data_rdata    = '0;
    tick();
    tick();
    settle();
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_rdata", read_dataM, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    resetn = 1'b1;

    // lw 0x40: addr_ok in REQ, data_ok two cycles later
    tick();
    mem_read_enM = 1'b1;
    addrM = 32'h40;
    settle();
    chk("lw_c0_stall", 32'(stallM), 32'd1);
    chk("lw_c0_req", 32'(data_req), 32'd0);
    tick();
    data_addr_ok = 1'b1;
    settle();
    chk("lw_c1_req", 32'(data_req), 32'd1);
    chk("lw_c1_wr", 32'(data_wr), 32'd0);
    chk("lw_c1_addr", data_addr, 32'h40);
    chk("lw_c1_wstrb", 32'(data_wstrb), 32'h0);
    chk("lw_c1_stall", 32'(stallM), 32'd1);
    tick();
    data_addr_ok = 1'b0;
    settle();
    chk("lw_c2_req", 32'(data_req), 32'd0);
    chk("lw_c2_stall", 32'(stallM), 32'd1);
    tick();
    data_data_ok = 1'b1;
    data_rdata = 32'hDEADBEEF;
    settle();
    chk("lw_c3_req", 32'(data_req), 32'd0);
    chk("lw_c3_stall", 32'(stallM), 32'd1);
    tick();
    data_data_ok = 1'b0;
    data_rdata = 32'h0;
    settle();
    chk("lw_done_stall", 32'(stallM), 32'd0);
    chk("lw_done_rdata", read_dataM, 32'hDEADBEEF);
    tick();
    mem_read_enM = 1'b0;
    settle();
    chk("lw_idle_stall", 32'(stallM), 32'd0);
    chk("lw_idle_req", 32'(data_req), 32'd0);
    chk("lw_idle_rdata", read_dataM, 32'hDEADBEEF);

    // sw 0x12345678 -> 0x100, addr_ok after 3 wait cycles with data_ok
    mem_write_enM = 1'b1;
    addrM = 32'h100;
    write_dataM = 32'h12345678;
    settle();
    chk("sw_c0_stall", 32'(stallM), 32'd1);
    tick();
    addrM = 32'h200;
    write_dataM = 32'hFFFF0000;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_req", 32'(data_req), 32'd1);
      chk("sw_wait_addr", data_addr, 32'h100);
      chk("sw_wait_wdata", data_wdata, 32'h12345678);
      chk("sw_wait_wr", 32'(data_wr), 32'd1);
      chk("sw_wait_wstrb", 32'(data_wstrb), 32'hF);
      chk("sw_wait_stall", 32'(stallM), 32'd1);
      tick();
    end
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'hBAD0BAD0;
    settle();
    chk("sw_c4_req", 32'(data_req), 32'd1);
    chk("sw_c4_addr", data_addr, 32'h100);
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    settle();
    chk("sw_done_req", 32'(data_req), 32'd0);
    chk("sw_done_stall", 32'(stallM), 32'd0);
    chk("sw_done_rdata", read_dataM, 32'hDEADBEEF);
    tick();
    mem_write_enM = 1'b0;
    settle();
    chk("sw_idle_stall", 32'(stallM), 32'd0);

    // lw finishing under stall_other, stray data_ok in DONE
    mem_read_enM = 1'b1;
    addrM = 32'h80;
    tick();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'hCAFEF00D;
    settle();
    chk("so_req", 32'(data_req), 32'd1);
    tick();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'h11111111;
    stall_other = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("so_done_stall", 32'(stallM), 32'd0);
      chk("so_done_req", 32'(data_req), 32'd0);
      chk("so_done_rdata", read_dataM, 32'hCAFEF00D);
      tick();
    end
    stall_other = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    settle();
    chk("so_drop_stall", 32'(stallM), 32'd0);
    chk("so_drop_rdata", read_dataM, 32'hCAFEF00D);
    tick();
    addrM = 32'h84;
    settle();
    chk("so_idle_newacc", 32'(stallM), 32'd1);
    chk("so_idle_req", 32'(data_req), 32'd0);
    tick();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'h55AA55AA;
    settle();
    chk("so2_addr", data_addr, 32'h84);
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    settle();
    chk("so2_rdata", read_dataM, 32'h55AA55AA);
    tick();
    mem_read_enM = 1'b0;

    // misaligned lw / sw
    mem_read_enM = 1'b1;
    addrM = 32'h42;
    settle();
    chk("mis_lw_err", 32'(addr_errM), 32'd1);
    chk("mis_lw_stall", 32'(stallM), 32'd0);
    tick();
    chk("mis_lw_req", 32'(data_req), 32'd0);
    chk("mis_lw_stall2", 32'(stallM), 32'd0);
    mem_read_enM = 1'b0;
    mem_write_enM = 1'b1;
    addrM = 32'h101;
    settle();
    chk("mis_sw_err", 32'(addr_errM), 32'd1);
    chk("mis_sw_stall", 32'(stallM), 32'd0);
    tick();
    chk("mis_sw_req", 32'(data_req), 32'd0);
    mem_write_enM = 1'b0;
    settle();
    chk("noen_err", 32'(addr_errM), 32'd0);

    // flush in IDLE
    mem_read_enM = 1'b1;
    flushM = 1'b1;
    addrM = 32'h40;
    settle();
    chk("fl_idle_stall", 32'(stallM), 32'd0);
    chk("fl_idle_err", 32'(addr_errM), 32'd0);
    tick();
    chk("fl_idle_req", 32'(data_req), 32'd0);
    chk("fl_idle_stall2", 32'(stallM), 32'd0);

    // flush raised while in REQ
    flushM = 1'b0;
    addrM = 32'h44;
    tick();
    flushM = 1'b1;
    settle();
    chk("fl_req_c1", 32'(data_req), 32'd1);
    chk("fl_req_stall", 32'(stallM), 32'd1);
    tick();
    chk("fl_req_c2", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'h0BADF00D;
    settle();
    chk("fl_wait_req", 32'(data_req), 32'd0);
    chk("fl_wait_stall", 32'(stallM), 32'd1);
    tick();
    data_data_ok = 1'b0;
    settle();
    chk("fl_done_rdata", read_dataM, 32'h0BADF00D);
    chk("fl_done_stall", 32'(stallM), 32'd0);
    tick();
    flushM = 1'b0;
    mem_read_enM = 1'b0;

    // reset during WAIT, then a stray data_ok
    mem_read_enM = 1'b1;
    addrM = 32'h48;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    resetn = 1'b0;
    settle();
    chk("rw_wait_req", 32'(data_req), 32'd0);
    chk("rw_wait_stall", 32'(stallM), 32'd1);
    tick();
    resetn = 1'b1;
    mem_read_enM = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'hFFFFFFFF;
    settle();
    chk("rw_rst_req", 32'(data_req), 32'd0);
    chk("rw_rst_stall", 32'(stallM), 32'd0);
    chk("rw_rst_rdata", read_dataM, 32'h0);
    chk("rw_rst_addr", data_addr, 32'h0);
    tick();
    data_data_ok = 1'b0;
    settle();
    chk("rw_stray_rdata", read_dataM, 32'h0);
    chk("rw_stray_req", 32'(data_req), 32'd0);
    chk("rw_stray_stall", 32'(stallM), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
